thumb_dmem_responder: RTL and testbench
=======================================

THUMB_DMEM_RESPONDER -- requirements
Module: thumb_dmem_responder

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data word width.
REQ-002 SHALL have parameter ADDR_BITS, default 8, memory index width; depth = 2^ADDR_BITS words.
REQ-003 SHALL have parameter READ_LAT, default 4, clocks from read request to valid data (range 1-15).
REQ-004 SHALL have parameter WRITE_LAT, default 4, clocks from write strobe release to array commit (range 1-15).
REQ-005 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: read_data_n  in  1  active-low read strobe from processor.
REQ-008 SHALL have ports: write_data_n  in  1  active-low write strobe from processor.
REQ-009 SHALL have ports: data_address  in  WORD_SIZE  processor address; bits [ADDR_BITS-1:0] index the array.
REQ-010 SHALL have ports: data_in  in  WORD_SIZE  processor write data.
REQ-011 SHALL have ports: data_out  out  WORD_SIZE  read data; data_oe  out  1  drive-enable for the external tristate.
REQ-012 SHALL have ports: host_req  in  1, host_we  in  1, host_addr  in  ADDR_BITS, host_wdata  in  WORD_SIZE  host preload/readback port.
REQ-013 SHALL have ports: host_ack  out  1, host_rdata  out  WORD_SIZE  host completion pulse and read data.

Function
REQ-014 Read FSM SHALL have states R_IDLE, R_WAIT, R_VALID.
REQ-015 R_IDLE -> R_WAIT when read_data_n sampled 0; latch index; load counter READ_LAT-1.
REQ-016 R_WAIT SHALL decrement per clock; at 0 -> R_VALID with data_out = word at latched index, data_oe = 1.
REQ-017 R_VALID SHALL hold data_out/data_oe while read_data_n = 0 and index unchanged.
REQ-018 Index change during R_WAIT or R_VALID SHALL re-latch, drop data_oe, reload counter, enter R_WAIT.
REQ-019 read_data_n sampled 1 in any read state SHALL return to R_IDLE with data_oe = 0 next clock; data_out holds its last value.
REQ-020 Write FSM SHALL have states W_IDLE, W_CAPTURE, W_PENDING.
REQ-021 W_CAPTURE SHALL be entered when write_data_n sampled 0; index and data_in re-captured every clock while low (last value wins).
REQ-022 write_data_n sampled 1 in W_CAPTURE -> W_PENDING, counter = WRITE_LAT-1; commit to array when counter reaches 0, then W_IDLE.
REQ-023 write_data_n sampled 0 during W_PENDING SHALL commit the pending word that clock, then enter W_CAPTURE for the new write.
REQ-024 Read whose index matches a W_PENDING index SHALL return the pending data (forwarding), not the stale array word.
REQ-025 Simultaneous read and write strobes SHALL both proceed; read of the capturing index returns pre-write array contents.
REQ-026 Host access SHALL be serviced in one clock when no processor commit occurs that clock: host_ack = 1 for one clock; write stores host_wdata; read returns host_rdata next to ack.
REQ-027 Processor commit SHALL have priority; a colliding host request SHALL be held off (host_ack = 0) until the following clock; host_req must stay high until host_ack.
REQ-028 Upper address bits above ADDR_BITS SHALL be ignored (wrap-around aliasing).

Reset
REQ-029 reset SHALL force R_IDLE, W_IDLE, data_oe = 0, data_out = 0, host_ack = 0, host_rdata = 0, counters = 0.
REQ-030 reset SHALL discard a pending uncommitted write; array contents SHALL NOT be cleared.
REQ-031 reset mid-read SHALL drop data_oe the clock after reset is sampled.

Structure
REQ-032 WORD_SIZE, default latencies and FSM state encodings SHALL reside in the shared thumb definitions package.
REQ-033 The storage SHALL be one sub-module, dmem_array (one shared write port, two read ports), instantiated once.

Verification
REQ-034 Host write 0x0000000A to index 0, processor read index 0 -> data_oe rises exactly 4 clocks after strobe, data_out = 0x0000000A.
REQ-035 Processor write 0xFFFFFFFC to index 24, strobe released -> array updates 4 clocks later; host read index 24 returns 0xFFFFFFFC.
REQ-036 Write 0x4 to index 24 then read index 24 within 2 clocks of release -> read returns 0x4 via forwarding.
REQ-037 Back-to-back writes (0x11 idx 4, 0x22 idx 8) with 1-clock gap -> both committed, idx 4 = 0x11, idx 8 = 0x22.
REQ-038 Address changes 0 -> 4 at clock 2 of read -> data_oe low, counter restarts, word at index 4 valid 4 clocks after change.
REQ-039 reset asserted in W_PENDING for write 0x55 to idx 12 -> idx 12 keeps old value, data_oe = 0, host_ack = 0.

Source files
------------

// File: rtl/thumb_dmem_responder_pkg.sv
// Shared thumb data-memory definitions: word size, default latencies,
// FSM state encodings and the debug snapshot of both FSMs.
package thumb_dmem_responder_pkg;

  localparam int DMEM_WORD_SIZE = 32;
  localparam int DEF_ADDR_BITS  = 8;
  localparam int DEF_READ_LAT   = 4;
  localparam int DEF_WRITE_LAT  = 4;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_VALID = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_CAPTURE = 2'd1,
    W_PENDING = 2'd2
  } wr_state_t;

  typedef struct packed {
    rd_state_t        rd_state;
    wr_state_t        wr_state;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;
  } dbg_t;

  // Countdown preload: the FSM spends lat clocks counting lat-1 down to 0.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/thumb_dmem_responder_if.sv
// Processor strobe bus plus host preload/readback port of the data memory.
interface thumb_dmem_responder_if
  import thumb_dmem_responder_pkg::*;
#(
  parameter int WORD_SIZE = DMEM_WORD_SIZE,
  parameter int ADDR_BITS = DEF_ADDR_BITS
);

  logic                 read_data_n;
  logic                 write_data_n;
  logic [WORD_SIZE-1:0] data_address;
  logic [WORD_SIZE-1:0] data_in;
  logic [WORD_SIZE-1:0] data_out;
  logic                 data_oe;

  // Host handshake: host_req is held high with stable host_we/addr/wdata until
  // host_ack is seen; host_ack is a one-clock pulse with host_rdata valid
  // alongside it, and the host drops host_req in that same clock.
  logic                 host_req;
  logic                 host_we;
  logic [ADDR_BITS-1:0] host_addr;
  logic [WORD_SIZE-1:0] host_wdata;
  logic                 host_ack;
  logic [WORD_SIZE-1:0] host_rdata;

  modport master (
    output read_data_n, write_data_n, data_address, data_in,
    output host_req, host_we, host_addr, host_wdata,
    input  data_out, data_oe, host_ack, host_rdata
  );

  modport slave (
    input  read_data_n, write_data_n, data_address, data_in,
    input  host_req, host_we, host_addr, host_wdata,
    output data_out, data_oe, host_ack, host_rdata
  );

endinterface

// File: rtl/thumb_dmem_responder_dmem_array.sv
// Word-wide storage: one shared synchronous write port, two asynchronous read
// ports. Contents are intentionally never reset.
module dmem_array
  import thumb_dmem_responder_pkg::*;
#(
  parameter int WORD_SIZE = DMEM_WORD_SIZE,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [WORD_SIZE-1:0] i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr_a,
  output logic [WORD_SIZE-1:0] o_rdata_a,
  input  logic [ADDR_BITS-1:0] i_raddr_b,
  output logic [WORD_SIZE-1:0] o_rdata_b
);

  logic [WORD_SIZE-1:0] r_mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/thumb_dmem_responder.sv
// Latency-emulating data memory for a thumb core: read and write FSMs on the
// processor strobes, write forwarding, and a lower-priority host port.
module thumb_dmem_responder
  import thumb_dmem_responder_pkg::*;
#(
  parameter int WORD_SIZE = DMEM_WORD_SIZE,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int READ_LAT  = DEF_READ_LAT,
  parameter int WRITE_LAT = DEF_WRITE_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  thumb_dmem_responder_if.slave bus,
  output dbg_t                  o_dbg
);

  rd_state_t            r_rd_state;
  logic [CNT_W-1:0]     r_rd_cnt;
  logic [ADDR_BITS-1:0] r_rd_idx;
  logic [WORD_SIZE-1:0] r_data_out;
  logic                 r_data_oe;

  wr_state_t            r_wr_state;
  logic [CNT_W-1:0]     r_wr_cnt;
  logic [ADDR_BITS-1:0] r_wr_idx;
  logic [WORD_SIZE-1:0] r_wr_data;

  logic                 r_host_ack;
  logic [WORD_SIZE-1:0] r_host_rdata;

  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_unused_addr_hi;
  logic                 w_commit;
  logic                 w_host_go;
  logic                 w_arr_we;
  logic [ADDR_BITS-1:0] w_arr_waddr;
  logic [WORD_SIZE-1:0] w_arr_wdata;
  logic [WORD_SIZE-1:0] w_arr_rdata_a;
  logic [WORD_SIZE-1:0] w_arr_rdata_b;
  logic                 w_fwd_hit;
  logic [WORD_SIZE-1:0] w_rd_word;

  // Upper address bits alias onto the array.
  assign w_idx            = bus.data_address[ADDR_BITS-1:0];
  assign w_unused_addr_hi = ^bus.data_address[WORD_SIZE-1:ADDR_BITS];

  // A pending word commits when its countdown expires or a new write preempts it.
  assign w_commit  = (r_wr_state == W_PENDING) &&
                     ((r_wr_cnt == '0) || !bus.write_data_n);
  assign w_host_go = bus.host_req && !w_commit;

  assign w_arr_we    = w_commit || (w_host_go && bus.host_we);
  assign w_arr_waddr = w_commit ? r_wr_idx  : bus.host_addr;
  assign w_arr_wdata = w_commit ? r_wr_data : bus.host_wdata;

  // Only a pending word forwards; a write still capturing leaves reads on the old array word.
  assign w_fwd_hit = (r_wr_state == W_PENDING) && (r_wr_idx == r_rd_idx);
  assign w_rd_word = w_fwd_hit ? r_wr_data : w_arr_rdata_a;

  dmem_array #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_BITS (ADDR_BITS)
  ) u_dmem_array (
    .clk       (clk),
    .i_we      (w_arr_we),
    .i_waddr   (w_arr_waddr),
    .i_wdata   (w_arr_wdata),
    .i_raddr_a (r_rd_idx),
    .o_rdata_a (w_arr_rdata_a),
    .i_raddr_b (bus.host_addr),
    .o_rdata_b (w_arr_rdata_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_state <= R_IDLE;
      r_rd_cnt   <= '0;
      r_rd_idx   <= '0;
      r_data_out <= '0;
      r_data_oe  <= 1'b0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (!bus.read_data_n) begin
            r_rd_state <= R_WAIT;
            r_rd_idx   <= w_idx;
            r_rd_cnt   <= lat_load(READ_LAT);
          end
        end
        R_WAIT: begin
          if (bus.read_data_n) begin
            r_rd_state <= R_IDLE;
            r_rd_cnt   <= '0;
          end else if (w_idx != r_rd_idx) begin
            r_rd_idx <= w_idx;
            r_rd_cnt <= lat_load(READ_LAT);
          end else if (r_rd_cnt == '0) begin
            r_rd_state <= R_VALID;
            r_data_out <= w_rd_word;
            r_data_oe  <= 1'b1;
          end else begin
            r_rd_cnt <= r_rd_cnt - CNT_W'(1);
          end
        end
        R_VALID: begin
          if (bus.read_data_n) begin
            r_rd_state <= R_IDLE;
            r_data_oe  <= 1'b0;
          end else if (w_idx != r_rd_idx) begin
            r_rd_state <= R_WAIT;
            r_rd_idx   <= w_idx;
            r_rd_cnt   <= lat_load(READ_LAT);
            r_data_oe  <= 1'b0;
          end
        end
        default: begin
          r_rd_state <= R_IDLE;
          r_rd_cnt   <= '0;
          r_data_oe  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state <= W_IDLE;
      r_wr_cnt   <= '0;
      r_wr_idx   <= '0;
      r_wr_data  <= '0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (!bus.write_data_n) begin
            r_wr_state <= W_CAPTURE;
            r_wr_idx   <= w_idx;
            r_wr_data  <= bus.data_in;
          end
        end
        W_CAPTURE: begin
          if (!bus.write_data_n) begin
            r_wr_idx  <= w_idx;
            r_wr_data <= bus.data_in;
          end else begin
            r_wr_state <= W_PENDING;
            r_wr_cnt   <= lat_load(WRITE_LAT);
          end
        end
        W_PENDING: begin
          // The commit itself happens through w_commit on this same edge.
          if (!bus.write_data_n) begin
            r_wr_state <= W_CAPTURE;
            r_wr_cnt   <= '0;
            r_wr_idx   <= w_idx;
            r_wr_data  <= bus.data_in;
          end else if (r_wr_cnt == '0) begin
            r_wr_state <= W_IDLE;
          end else begin
            r_wr_cnt <= r_wr_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_wr_state <= W_IDLE;
          r_wr_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_host_ack   <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      r_host_ack <= w_host_go;
      if (w_host_go && !bus.host_we) r_host_rdata <= w_arr_rdata_b;
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_oe    = r_data_oe;
  assign bus.host_ack   = r_host_ack;
  assign bus.host_rdata = r_host_rdata;

  assign o_dbg.rd_state = r_rd_state;
  assign o_dbg.wr_state = r_wr_state;
  assign o_dbg.rd_cnt   = r_rd_cnt;
  assign o_dbg.wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_thumb_dmem_responder.sv
// Directed bench for thumb_dmem_responder: read/write latency, forwarding,
// address change, host priority, reset behaviour and address aliasing.
module tb_thumb_dmem_responder;
  import thumb_dmem_responder_pkg::*;

  localparam int W  = 32;
  localparam int AB = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  dbg_t dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  thumb_dmem_responder_if #(.WORD_SIZE(W), .ADDR_BITS(AB)) bus ();

  thumb_dmem_responder #(
    .WORD_SIZE (W),
    .ADDR_BITS (AB),
    .READ_LAT  (4),
    .WRITE_LAT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .o_dbg (dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic host_op(input logic we, input logic [AB-1:0] addr,
                         input logic [W-1:0] wdata, output logic [W-1:0] rdata);
    int n = 0;
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wdata;
    tick();
    while (!bus.host_ack && n < 8) begin
      tick();
      n++;
    end
    check("host_ack", W'(bus.host_ack), 1);
    rdata        = bus.host_rdata;
    bus.host_req = 1'b0;
    bus.host_we  = 1'b0;
    tick();
    check("host_ack_pulse", W'(bus.host_ack), 0);
  endtask

  task automatic host_write(input logic [AB-1:0] addr, input logic [W-1:0] data);
    logic [W-1:0] dummy;
    host_op(1'b1, addr, data, dummy);
  endtask

  task automatic host_read_expect(input string tag, input logic [AB-1:0] addr,
                                  input logic [W-1:0] exp);
    logic [W-1:0] got;
    exp_q.push_back(exp);
    host_op(1'b0, addr, '0, got);
    check(tag, got, exp_q.pop_front());
  endtask

  // Counts clocks after the current point until data_oe rises (bounded).
  task automatic wait_oe(output int lat);
    lat = 0;
    while (!bus.data_oe && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic proc_write(input logic [W-1:0] addr, input logic [W-1:0] data);
    bus.write_data_n = 1'b0;
    bus.data_address = addr;
    bus.data_in      = data;
    tick();
    bus.write_data_n = 1'b1;
    tick();
  endtask

  initial begin
    int lat;
    logic [W-1:0] rd;
    bus.read_data_n  = 1'b1;
    bus.write_data_n = 1'b1;
    bus.data_address = '0;
    bus.data_in      = '0;
    bus.host_req     = 1'b0;
    bus.host_we      = 1'b0;
    bus.host_addr    = '0;
    bus.host_wdata   = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check("rst_oe",    W'(bus.data_oe), 0);
    check("rst_dout",  bus.data_out, 0);
    check("rst_ack",   W'(bus.host_ack), 0);
    check("rst_rdata", bus.host_rdata, 0);
    check("rst_dbg",   W'(dbg), 0);
    reset = 1'b0;
    tick();

    // Host preload then processor read with 4-clock latency
    host_write(8'd0, 32'h0000_000A);
    bus.data_address = 32'd0;
    bus.read_data_n  = 1'b0;
    tick();
    check("rd_oe_early", W'(bus.data_oe), 0);
    wait_oe(lat);
    check("rd_lat", W'(lat), 4);
    check("rd_data", bus.data_out, 32'h0000_000A);
    bus.read_data_n = 1'b1;
    tick();
    check("rd_release_oe", W'(bus.data_oe), 0);
    check("rd_release_hold", bus.data_out, 32'h0000_000A);

    // Processor write commits 4 clocks after release; host sees stale word before
    host_write(8'd24, 32'h1234_5678);
    proc_write(32'd24, 32'hFFFF_FFFC);
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 8'd24;
    tick();
    check("wr_stale_ack", W'(bus.host_ack), 1);
    check("wr_stale_data", bus.host_rdata, 32'h1234_5678);
    bus.host_req = 1'b0;
    tick();
    tick();
    check("wr_pend_3", W'(dbg.wr_state), W'(W_PENDING));
    tick();
    check("wr_done_4", W'(dbg.wr_state), W'(W_IDLE));
    host_read_expect("wr_commit", 8'd24, 32'hFFFF_FFFC);

    // Read launched on the release edge hits the pending word (forwarding)
    bus.write_data_n = 1'b0;
    bus.data_address = 32'd24;
    bus.data_in      = 32'h0000_0004;
    tick();
    bus.write_data_n = 1'b1;
    bus.read_data_n  = 1'b0;
    tick();
    wait_oe(lat);
    check("fwd_lat", W'(lat), 4);
    check("fwd_data", bus.data_out, 32'h0000_0004);
    bus.read_data_n = 1'b1;
    tick();
    host_read_expect("fwd_commit", 8'd24, 32'h0000_0004);

    // Simultaneous strobes: read of the capturing index returns old contents
    host_write(8'd40, 32'h0BAD_F00D);
    bus.data_address = 32'd40;
    bus.data_in      = 32'h0000_0077;
    bus.read_data_n  = 1'b0;
    bus.write_data_n = 1'b0;
    tick();
    wait_oe(lat);
    check("simul_lat", W'(lat), 4);
    check("simul_data", bus.data_out, 32'h0BAD_F00D);
    bus.read_data_n  = 1'b1;
    bus.write_data_n = 1'b1;
    repeat (6) tick();
    host_read_expect("simul_commit", 8'd40, 32'h0000_0077);

    // Back-to-back writes with a one-clock gap
    proc_write(32'd4, 32'h0000_0011);
    proc_write(32'd8, 32'h0000_0022);
    repeat (5) tick();
    host_read_expect("b2b_idx4", 8'd4, 32'h0000_0011);
    host_read_expect("b2b_idx8", 8'd8, 32'h0000_0022);

    // Address change mid-wait restarts latency; change in valid drops oe (aliased address)
    bus.data_address = 32'd0;
    bus.read_data_n  = 1'b0;
    tick();
    tick();
    bus.data_address = 32'd4;
    tick();
    check("chg_oe", W'(bus.data_oe), 0);
    wait_oe(lat);
    check("chg_lat", W'(lat), 4);
    check("chg_data", bus.data_out, 32'h0000_0011);
    bus.data_address = 32'hABCD_0108;
    tick();
    check("chg_valid_oe", W'(bus.data_oe), 0);
    wait_oe(lat);
    check("alias_lat", W'(lat), 4);
    check("alias_data", bus.data_out, 32'h0000_0022);
    bus.read_data_n = 1'b1;
    tick();

    // Host request colliding with a commit is held off one clock
    proc_write(32'd50, 32'h0000_005A);
    repeat (3) tick();
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 8'd60;
    bus.host_wdata = 32'h0000_0060;
    tick();
    check("coll_held", W'(bus.host_ack), 0);
    tick();
    check("coll_ack", W'(bus.host_ack), 1);
    bus.host_req = 1'b0;
    bus.host_we  = 1'b0;
    tick();
    host_read_expect("coll_proc", 8'd50, 32'h0000_005A);
    host_read_expect("coll_host", 8'd60, 32'h0000_0060);

    // Reset during a pending write discards it
    host_write(8'd12, 32'hCAFE_0012);
    proc_write(32'h0000_0F0C, 32'h0000_0055);
    tick();
    check("rstw_pend", W'(dbg.wr_state), W'(W_PENDING));
    reset = 1'b1;
    tick();
    check("rstw_dbg", W'(dbg), 0);
    check("rstw_oe", W'(bus.data_oe), 0);
    check("rstw_ack", W'(bus.host_ack), 0);
    reset = 1'b0;
    repeat (6) tick();
    host_read_expect("rstw_keep", 8'd12, 32'hCAFE_0012);

    // Aliased processor write lands on index 12
    proc_write(32'h1234_560C, 32'h0000_0066);
    repeat (5) tick();
    host_read_expect("alias_wr", 8'd12, 32'h0000_0066);

    // Reset mid-read drops oe and clears data_out next clock
    bus.data_address = 32'd0;
    bus.read_data_n  = 1'b0;
    tick();
    wait_oe(lat);
    check("rstr_lat", W'(lat), 4);
    reset = 1'b1;
    tick();
    check("rstr_oe", W'(bus.data_oe), 0);
    check("rstr_dout", bus.data_out, 0);
    reset = 1'b0;
    bus.read_data_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
